// File: rtl/seg7_frame_monitor_if.sv
// Multiplexed seven-segment display pins (anode/cathode pair) as seen by a scanner and a snooper.
interface seg7_frame_monitor_if;
  logic [3:0] anode_in;
  logic [6:0] cathode_in;

  modport master (output anode_in, output cathode_in);
  modport slave  (input  anode_in, input  cathode_in);
endinterface

// File: rtl/seg7_frame_monitor.sv
// Snoops a 4-digit multiplexed seven-segment display and rebuilds score/seconds frames,
// flagging illegal segment patterns and a display that has stopped refreshing.
module seg7_frame_monitor #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_frame_monitor_if.slave  disp,
  output logic [6:0]           score,
  output logic [3:0]           sec_tens,
  output logic [3:0]           sec_ones,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic                 stale
);

  localparam int unsigned AW  = 4;
  localparam int unsigned CW  = 7;
  localparam int unsigned PW  = AW + CW;
  localparam int unsigned DW  = 4;
  localparam int unsigned NS  = 4;
  localparam int unsigned SW  = 7;
  localparam int unsigned SCW = 8;
  localparam int unsigned TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SCW-1:0] STABLE_HIT = SCW'(STABLE_CYCLES - 2);
  localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]  TO_MAX     = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [AW-1:0] AN_IDLE = 4'hF;
  localparam logic [CW-1:0] CA_IDLE = 7'h7F;

  // Synchroniser and previous-sample registers
  logic [AW-1:0]         an_s1_q, an_s2_q;
  logic [CW-1:0]         ca_s1_q, ca_s2_q;
  logic [PW-1:0]         prev_q;

  // Stability filter and slot capture state
  logic [SCW-1:0]        stab_q, stab_d;
  logic [NS-1:0]         mask_q, mask_d;
  logic [NS-1:0]         err_q,  err_d;
  logic [NS-1:0][DW-1:0] dig_q,  dig_d;

  // Frame outputs and timeout state
  logic [SW-1:0]         score_q, score_d;
  logic [DW-1:0]         tens_q,  tens_d;
  logic [DW-1:0]         ones_q,  ones_d;
  logic                  fv_q,    fv_d;
  logic                  ferr_q,  ferr_d;
  logic                  stale_q, stale_d;
  logic [TW-1:0]         to_q,    to_d;

  logic [PW-1:0]         samp_c;
  logic                  same_c;
  logic                  accept_c;
  logic                  complete_c;
  logic [NS-1:0]         sel_c;
  logic [DW-1:0]         dec_dig_c;
  logic                  dec_err_c;

  assign samp_c     = {an_s2_q, ca_s2_q};
  assign same_c     = (samp_c == prev_q);
  assign accept_c   = same_c && (stab_q == STABLE_HIT);
  assign complete_c = (mask_q == {NS{1'b1}});

  // 2-FF synchroniser on the pin pair plus the one-cycle-old sample for the filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q <= AN_IDLE;
      an_s2_q <= AN_IDLE;
      ca_s1_q <= CA_IDLE;
      ca_s2_q <= CA_IDLE;
      prev_q  <= {AN_IDLE, CA_IDLE};
    end else begin
      an_s1_q <= disp.anode_in;
      an_s2_q <= an_s1_q;
      ca_s1_q <= disp.cathode_in;
      ca_s2_q <= ca_s1_q;
      prev_q  <= samp_c;
    end
  end

  // Only a single active-low anode selects a slot; anything else is ignored
  always_comb begin
    sel_c = '0;
    case (an_s2_q)
      4'b0111: sel_c = 4'b1000;
      4'b1011: sel_c = 4'b0100;
      4'b1101: sel_c = 4'b0010;
      4'b1110: sel_c = 4'b0001;
      default: sel_c = '0;
    endcase
  end

  // Active-low segment decode; unknown patterns (blank included) read as 0 with error
  always_comb begin
    dec_dig_c = '0;
    dec_err_c = 1'b0;
    case (ca_s2_q)
      7'h01:   dec_dig_c = 4'd0;
      7'h4F:   dec_dig_c = 4'd1;
      7'h12:   dec_dig_c = 4'd2;
      7'h06:   dec_dig_c = 4'd3;
      7'h4C:   dec_dig_c = 4'd4;
      7'h24:   dec_dig_c = 4'd5;
      7'h20:   dec_dig_c = 4'd6;
      7'h0F:   dec_dig_c = 4'd7;
      7'h00:   dec_dig_c = 4'd8;
      7'h04:   dec_dig_c = 4'd9;
      default: dec_err_c = 1'b1;
    endcase
  end

  // Stability counter saturates one past the hit value so acceptance fires once per pair
  always_comb begin
    stab_d = '0;
    if (same_c) begin
      stab_d = (stab_q == STABLE_MAX) ? stab_q : stab_q + SCW'(1);
    end
  end

  // Slot capture; completion clears mask/errors, a same-cycle acceptance seeds the next frame
  always_comb begin
    mask_d = mask_q;
    err_d  = err_q;
    dig_d  = dig_q;
    if (complete_c) begin
      mask_d = '0;
      err_d  = '0;
    end
    if (accept_c) begin
      for (int i = 0; i < NS; i++) begin
        if (sel_c[i]) begin
          dig_d[i]  = dec_dig_c;
          err_d[i]  = dec_err_c;
          mask_d[i] = 1'b1;
        end
      end
    end
  end

  // Frame outputs hold between completions
  always_comb begin
    score_d = score_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ferr_d  = ferr_q;
    fv_d    = 1'b0;
    if (complete_c) begin
      score_d = SW'(dig_q[3]) * SW'(10) + SW'(dig_q[2]);
      tens_d  = dig_q[1];
      ones_d  = dig_q[0];
      ferr_d  = |err_q;
      fv_d    = 1'b1;
    end
  end

  // Timeout: a completing frame always overrides the stale condition
  always_comb begin
    to_d    = (to_q == TO_MAX) ? to_q : to_q + TW'(1);
    stale_d = stale_q | (to_d == TO_MAX);
    if (complete_c) begin
      to_d    = '0;
      stale_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q  <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      dig_q   <= '0;
      score_q <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      fv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      stale_q <= 1'b0;
      to_q    <= '0;
    end else begin
      stab_q  <= stab_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      dig_q   <= dig_d;
      score_q <= score_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      fv_q    <= fv_d;
      ferr_q  <= ferr_d;
      stale_q <= stale_d;
      to_q    <= to_d;
    end
  end

  assign score       = score_q;
  assign sec_tens    = tens_q;
  assign sec_ones    = ones_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign stale       = stale_q;

endmodule
